ctrl_pipeline: RTL and testbench

CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

---
 rtl/lc3b_types.sv | 30 +++
 rtl/ctrl_pipeline_hazard_detect.sv | 58 +++++
 rtl/ctrl_pipeline.sv | 109 ++++++++++
 tb/tb_ctrl_pipeline.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared control word, bubble constant and stage record for the LC-3b pipeline
package lc3b_types;

    // Decoded control word carried down the pipeline with each instruction
    typedef struct packed {
        logic [3:0] opcode;
        logic [1:0] alu_op;
        logic       load_pc;
        logic       load_ir;
        logic       load_mar;
        logic       load_mdr;
        logic       cc_load;
        logic       regFile_load;
        logic       mem2_read;
        logic       mem2_write;
    } lc3b_control;

    // Bubble control word: no load, read, write or register/cc update
    localparam lc3b_control CTRL_NOP = '0;

    // One pipeline stage register: control word, valid bit and destination register
    typedef struct packed {
        lc3b_control ctrl;
        logic        valid;
        logic [2:0]  dest;
    } stage_t;

    localparam stage_t STAGE_NOP = '{ctrl: CTRL_NOP, valid: 1'b0, dest: 3'd0};

endpackage

// File: rtl/ctrl_pipeline_hazard_detect.sv
// rtl/ctrl_pipeline_hazard_detect.sv - memory-busy, load-use and branch redirect steering
module hazard_detect (
    input  logic       rst,
    input  logic       ex_valid,
    input  logic       ex_mem2_read,
    input  logic       ex_regfile_load,
    input  logic [2:0] ex_dest,
    input  logic       mem_valid,
    input  logic       mem_mem2_read,
    input  logic       mem_mem2_write,
    input  logic       id_valid,
    input  logic [2:0] id_sr1,
    input  logic [2:0] id_sr2,
    input  logic       id_sr2_used,
    input  logic       mem2_resp,
    input  logic       br_taken,
    output logic       stage_hold,
    output logic       ex_bubble,
    output logic       wb_bubble,
    output logic       pipe_stall,
    output logic       id_flush
);

    logic mem_busy;
    logic load_use;
    logic br_redirect;

    assign mem_busy = mem_valid & (mem_mem2_read | mem_mem2_write) & ~mem2_resp;

    assign load_use = ex_valid & ex_mem2_read & ex_regfile_load & id_valid &
                      ((ex_dest == id_sr1) | (id_sr2_used & (ex_dest == id_sr2)));

    // A redirect only counts when a real instruction sits in MEM and memory is not stalling it
    assign br_redirect = br_taken & mem_valid & ~mem_busy;

    // Priority: memory stall freezes everything, then branch redirect, then load-use bubble
    always_comb begin
        stage_hold = 1'b0;
        ex_bubble  = 1'b0;
        wb_bubble  = 1'b0;
        pipe_stall = 1'b0;
        id_flush   = 1'b0;
        if (!rst) begin
            if (mem_busy) begin
                stage_hold = 1'b1;
                wb_bubble  = 1'b1;
                pipe_stall = 1'b1;
            end else if (br_redirect) begin
                ex_bubble = 1'b1;
                id_flush  = 1'b1;
            end else if (load_use) begin
                ex_bubble  = 1'b1;
                pipe_stall = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// rtl/ctrl_pipeline.sv - EX/MEM/WB control pipeline with stall, flush and stall counting
module ctrl_pipeline
    import lc3b_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  lc3b_control      id_ctrl,
    input  logic             id_valid,
    input  logic [2:0]       id_dest,
    input  logic [2:0]       id_sr1,
    input  logic [2:0]       id_sr2,
    input  logic             id_sr2_used,
    input  logic             mem2_resp,
    input  logic             br_taken,
    output lc3b_control      ex_ctrl,
    output logic             ex_valid,
    output lc3b_control      mem_ctrl,
    output logic             mem_valid,
    output lc3b_control      wb_ctrl,
    output logic             wb_valid,
    output logic [2:0]       wb_dest,
    output logic             pipe_stall,
    output logic             id_flush,
    output logic [CNT_W-1:0] stall_count
);

    stage_t ex_q;
    stage_t mem_q;
    stage_t wb_q;

    logic stage_hold;
    logic ex_bubble;
    logic wb_bubble;

    hazard_detect u_hazard (
        .rst             (rst),
        .ex_valid        (ex_q.valid),
        .ex_mem2_read    (ex_q.ctrl.mem2_read),
        .ex_regfile_load (ex_q.ctrl.regFile_load),
        .ex_dest         (ex_q.dest),
        .mem_valid       (mem_q.valid),
        .mem_mem2_read   (mem_q.ctrl.mem2_read),
        .mem_mem2_write  (mem_q.ctrl.mem2_write),
        .id_valid        (id_valid),
        .id_sr1          (id_sr1),
        .id_sr2          (id_sr2),
        .id_sr2_used     (id_sr2_used),
        .mem2_resp       (mem2_resp),
        .br_taken        (br_taken),
        .stage_hold      (stage_hold),
        .ex_bubble       (ex_bubble),
        .wb_bubble       (wb_bubble),
        .pipe_stall      (pipe_stall),
        .id_flush        (id_flush)
    );

    // EX stage: hold on memory stall, bubble on redirect/load-use, else take ID
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= STAGE_NOP;
        end else if (!stage_hold) begin
            if (ex_bubble) begin
                ex_q <= STAGE_NOP;
            end else begin
                ex_q <= '{ctrl: id_ctrl, valid: id_valid, dest: id_dest};
            end
        end
    end

    // MEM stage: hold on memory stall, else take EX
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= STAGE_NOP;
        end else if (!stage_hold) begin
            mem_q <= ex_q;
        end
    end

    // WB stage: bubble while MEM waits on memory, else take MEM
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q <= STAGE_NOP;
        end else if (wb_bubble) begin
            wb_q <= STAGE_NOP;
        end else begin
            wb_q <= mem_q;
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (pipe_stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    assign ex_ctrl   = ex_q.ctrl;
    assign ex_valid  = ex_q.valid;
    assign mem_ctrl  = mem_q.ctrl;
    assign mem_valid = mem_q.valid;
    assign wb_ctrl   = wb_q.ctrl;
    assign wb_valid  = wb_q.valid;
    assign wb_dest   = wb_q.dest;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb/tb_ctrl_pipeline.sv - self-checking bench for ctrl_pipeline against a behavioural model
module tb_ctrl_pipeline;
    import lc3b_types::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    lc3b_control id_ctrl;
    logic        id_valid;
    logic [2:0]  id_dest, id_sr1, id_sr2;
    logic        id_sr2_used, mem2_resp, br_taken;

    lc3b_control ex_ctrl, mem_ctrl, wb_ctrl;
    logic        ex_valid, mem_valid, wb_valid;
    logic [2:0]  wb_dest;
    logic        pipe_stall, id_flush;
    logic [15:0] stall_count;

    lc3b_control ex_ctrl_b, mem_ctrl_b, wb_ctrl_b;
    logic        ex_valid_b, mem_valid_b, wb_valid_b;
    logic [2:0]  wb_dest_b;
    logic        pipe_stall_b, id_flush_b;
    logic [1:0]  stall_count_b;

    ctrl_pipeline #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_ctrl(id_ctrl), .id_valid(id_valid), .id_dest(id_dest),
        .id_sr1(id_sr1), .id_sr2(id_sr2), .id_sr2_used(id_sr2_used), .mem2_resp(mem2_resp),
        .br_taken(br_taken), .ex_ctrl(ex_ctrl), .ex_valid(ex_valid), .mem_ctrl(mem_ctrl),
        .mem_valid(mem_valid), .wb_ctrl(wb_ctrl), .wb_valid(wb_valid), .wb_dest(wb_dest),
        .pipe_stall(pipe_stall), .id_flush(id_flush), .stall_count(stall_count)
    );

    ctrl_pipeline #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .id_ctrl(id_ctrl), .id_valid(id_valid), .id_dest(id_dest),
        .id_sr1(id_sr1), .id_sr2(id_sr2), .id_sr2_used(id_sr2_used), .mem2_resp(mem2_resp),
        .br_taken(br_taken), .ex_ctrl(ex_ctrl_b), .ex_valid(ex_valid_b), .mem_ctrl(mem_ctrl_b),
        .mem_valid(mem_valid_b), .wb_ctrl(wb_ctrl_b), .wb_valid(wb_valid_b), .wb_dest(wb_dest_b),
        .pipe_stall(pipe_stall_b), .id_flush(id_flush_b), .stall_count(stall_count_b)
    );

    typedef struct {
        lc3b_control c;
        logic        v;
        logic [2:0]  d;
    } rec_t;

    rec_t m[3];          // index 0 = EX, 1 = MEM, 2 = WB
    int   m_cnt;
    int   m_cnt_b;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic lc3b_control mk(input logic [3:0] op, input logic rf, input logic rd,
                                       input logic wr, input logic ldpc);
        lc3b_control c;
        c = CTRL_NOP;
        c.opcode       = op;
        c.regFile_load = rf;
        c.cc_load      = rf;
        c.mem2_read    = rd;
        c.mem2_write   = wr;
        c.load_pc      = ldpc;
        return c;
    endfunction

    task automatic apply(input logic r, input lc3b_control c, input logic v, input logic [2:0] d,
                         input logic [2:0] s1, input logic [2:0] s2, input logic u,
                         input logic resp, input logic br);
        rst = r; id_ctrl = c; id_valid = v; id_dest = d; id_sr1 = s1; id_sr2 = s2;
        id_sr2_used = u; mem2_resp = resp; br_taken = br;
        #1;
    endtask

    // Compare every output with the model, then step the model and the clock together
    task automatic advance();
        logic busy, br, lu, e_stall, e_flush;
        rec_t nx[3];
        busy = m[1].v && (m[1].c.mem2_read || m[1].c.mem2_write) && !mem2_resp;
        br   = br_taken && m[1].v && !busy;
        lu   = m[0].v && m[0].c.mem2_read && m[0].c.regFile_load && id_valid &&
               ((m[0].d == id_sr1) || (id_sr2_used && (m[0].d == id_sr2)));
        e_stall = !rst && (busy || (lu && !br));
        e_flush = !rst && br;

        chk("ex_ctrl", 32'(ex_ctrl), 32'(m[0].c));
        chk("ex_valid", 32'(ex_valid), 32'(m[0].v));
        chk("mem_ctrl", 32'(mem_ctrl), 32'(m[1].c));
        chk("mem_valid", 32'(mem_valid), 32'(m[1].v));
        chk("wb_ctrl", 32'(wb_ctrl), 32'(m[2].c));
        chk("wb_valid", 32'(wb_valid), 32'(m[2].v));
        chk("wb_dest", 32'(wb_dest), 32'(m[2].d));
        chk("pipe_stall", 32'(pipe_stall), 32'(e_stall));
        chk("id_flush", 32'(id_flush), 32'(e_flush));
        chk("stall_count", 32'(stall_count), m_cnt);
        chk("stall_count_w2", 32'(stall_count_b), m_cnt_b);

        if (rst) begin
            for (int i = 0; i < 3; i++) nx[i] = '{c: CTRL_NOP, v: 1'b0, d: 3'd0};
        end else if (busy) begin
            nx[0] = m[0];
            nx[1] = m[1];
            nx[2] = '{c: CTRL_NOP, v: 1'b0, d: 3'd0};
        end else begin
            nx[2] = m[1];
            nx[1] = m[0];
            if (br || lu) nx[0] = '{c: CTRL_NOP, v: 1'b0, d: 3'd0};
            else          nx[0] = '{c: id_ctrl, v: id_valid, d: id_dest};
        end

        @(posedge clk);
        for (int i = 0; i < 3; i++) m[i] = nx[i];
        if (rst) begin
            m_cnt = 0;
            m_cnt_b = 0;
        end else if (e_stall) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_b < 3) m_cnt_b++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic resp);
        apply(1'b0, CTRL_NOP, 1'b0, 3'd0, 3'd7, 3'd7, 1'b0, resp, 1'b0);
    endtask

    task automatic reset_cycle();
        apply(1'b1, CTRL_NOP, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        advance();
    endtask

    lc3b_control c_add, c_and, c_ldr, c_br, rc;
    logic [31:0] r;

    initial begin
        c_add = mk(4'h1, 1'b1, 1'b0, 1'b0, 1'b0);
        c_and = mk(4'h5, 1'b1, 1'b0, 1'b0, 1'b0);
        c_ldr = mk(4'h6, 1'b1, 1'b1, 1'b0, 1'b0);
        c_br  = mk(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // First reset: outputs are unknown before it, so only seed the model afterwards
        @(negedge clk);
        apply(1'b1, CTRL_NOP, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) m[i] = '{c: CTRL_NOP, v: 1'b0, d: 3'd0};
        m_cnt = 0;
        m_cnt_b = 0;
        chk("reset_ex_valid", 32'(ex_valid), 0);
        chk("reset_wb_valid", 32'(wb_valid), 0);
        chk("reset_stall_count", 32'(stall_count), 0);
        chk("reset_pipe_stall", 32'(pipe_stall), 0);

        // ADD R1 then AND R2,R1,R3: one stage per cycle, no stall
        reset_cycle();
        apply(1'b0, c_add, 1'b1, 3'd1, 3'd4, 3'd5, 1'b0, 1'b1, 1'b0);
        advance();
        chk("add_in_ex", 32'(ex_ctrl), 32'(c_add));
        apply(1'b0, c_and, 1'b1, 3'd2, 3'd1, 3'd3, 1'b1, 1'b1, 1'b0);
        chk("add_and_no_stall", 32'(pipe_stall), 0);
        advance();
        chk("add_in_mem", 32'(mem_ctrl), 32'(c_add));
        chk("and_in_ex", 32'(ex_ctrl), 32'(c_and));
        idle(1'b1);
        advance();
        chk("add_in_wb", 32'(wb_ctrl), 32'(c_add));
        chk("add_wb_dest", 32'(wb_dest), 1);
        chk("and_in_mem", 32'(mem_ctrl), 32'(c_and));

        // LDR R1 in EX, ADD R2,R1,R3 in ID: one stall cycle and an EX bubble
        reset_cycle();
        apply(1'b0, c_ldr, 1'b1, 3'd1, 3'd6, 3'd6, 1'b0, 1'b1, 1'b0);
        advance();
        apply(1'b0, c_add, 1'b1, 3'd2, 3'd1, 3'd3, 1'b1, 1'b1, 1'b0);
        chk("lu_stall", 32'(pipe_stall), 1);
        advance();
        chk("lu_ex_bubble", 32'(ex_valid), 0);
        chk("lu_ldr_mem", 32'(mem_ctrl), 32'(c_ldr));
        chk("lu_count", 32'(stall_count), 1);
        apply(1'b0, c_add, 1'b1, 3'd2, 3'd1, 3'd3, 1'b1, 1'b1, 1'b0);
        chk("lu_released", 32'(pipe_stall), 0);
        advance();
        chk("lu_add_ex", 32'(ex_ctrl), 32'(c_add));

        // LDR in MEM with 4 cycles of no response
        reset_cycle();
        apply(1'b0, c_ldr, 1'b1, 3'd5, 3'd6, 3'd6, 1'b0, 1'b0, 1'b0);
        advance();
        idle(1'b0);
        advance();
        for (int k = 0; k < 4; k++) begin
            idle(1'b0);
            chk("busy_stall", 32'(pipe_stall), 1);
            advance();
            chk("busy_wb_bubble", 32'(wb_valid), 0);
            chk("busy_mem_frozen", 32'(mem_ctrl), 32'(c_ldr));
        end
        idle(1'b1);
        chk("busy_done", 32'(pipe_stall), 0);
        advance();
        chk("busy_ldr_wb", 32'(wb_ctrl), 32'(c_ldr));
        chk("busy_ldr_dest", 32'(wb_dest), 5);
        chk("busy_count", 32'(stall_count), 4);
        chk("busy_count_sat", 32'(stall_count_b), 3);
        idle(1'b1);
        advance();
        chk("busy_wb_once", 32'(wb_valid), 0);

        // Branch redirect in MEM while load-use is also true
        reset_cycle();
        apply(1'b0, c_br, 1'b1, 3'd0, 3'd6, 3'd6, 1'b0, 1'b1, 1'b0);
        advance();
        apply(1'b0, c_ldr, 1'b1, 3'd1, 3'd6, 3'd6, 1'b0, 1'b1, 1'b0);
        advance();
        apply(1'b0, c_add, 1'b1, 3'd2, 3'd1, 3'd3, 1'b1, 1'b1, 1'b1);
        chk("br_flush", 32'(id_flush), 1);
        chk("br_no_stall", 32'(pipe_stall), 0);
        advance();
        chk("br_ex_bubble", 32'(ex_valid), 0);
        chk("br_wb", 32'(wb_ctrl), 32'(c_br));

        // Reset in the middle of a memory stall
        reset_cycle();
        apply(1'b0, c_ldr, 1'b1, 3'd1, 3'd6, 3'd6, 1'b0, 1'b0, 1'b0);
        advance();
        idle(1'b0);
        advance();
        idle(1'b0);
        advance();
        apply(1'b1, CTRL_NOP, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_no_stall", 32'(pipe_stall), 0);
        chk("rst_no_flush", 32'(id_flush), 0);
        advance();
        chk("rst_mem_valid", 32'(mem_valid), 0);
        chk("rst_count", 32'(stall_count), 0);
        idle(1'b0);
        chk("rst_after_stall", 32'(pipe_stall), 0);
        advance();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            r = $urandom;
            rc = lc3b_control'(r[13:0]);
            if ($urandom_range(0, 3) != 0) rc.mem2_write = 1'b0;
            apply(($urandom_range(0, 199) == 0), rc, r[20], 3'($urandom_range(0, 3)),
                  3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), r[21],
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 7) == 0));
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
